// File: rtl/mha_pkg.sv
// Shared definitions for the MHA datapath: feeder FSM states, default array geometry
// and the array control-line encoding understood by the MAC cells.
package mha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WCOL,
        WSHIFT,
        STREAM,
        DRAIN
    } feeder_state_t;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_ROWS      = 4;
    localparam int DEF_COLS      = 4;
    localparam int DEF_CNT_W     = 8;

    // arr_control level that makes every MAC latch weight_in and clear feat/acc
    localparam logic READ_WEIGHT_DATA = 1'b1;

    // phase counter must reach ROWS+COLS-1 (longest phase is DRAIN)
    function automatic int phase_cnt_w(input int rows, input int cols);
        return $clog2(rows + cols) + 1;
    endfunction

endpackage

// File: rtl/mha_array_feeder_skew_line.sv
// One lane of the diagonal skew: a DELAY-deep register chain carrying data plus a valid bit.
// The last stage drives the array input directly, so the lane output is always registered.
module skew_line
    import mha_pkg::*;
#(
    parameter int bit_width = DEF_BIT_WIDTH,
    parameter int DELAY     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [bit_width-1:0] i_data,
    input  logic                 i_vld,
    output logic [bit_width-1:0] o_data,
    output logic                 o_vld
);

    logic [bit_width-1:0] r_data [DELAY];
    logic [DELAY-1:0]     r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DELAY; k++) begin
                r_data[k] <= '0;
            end
            r_vld <= '0;
        end else begin
            r_data[0] <= i_data;
            r_vld[0]  <= i_vld;
            for (int k = 1; k < DELAY; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
        end
    end

    assign o_data = r_data[DELAY-1];
    assign o_vld  = r_vld[DELAY-1];

endmodule

// File: rtl/mha_array_feeder.sv
// Feeds a weight-stationary systolic array: buffers a weight tile, shifts it in from the top
// row, streams diagonally skewed feature vectors into the left column, then flushes with zeros.
module mha_array_feeder
    import mha_pkg::*;
#(
    parameter int bit_width = DEF_BIT_WIDTH,
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [CNT_W-1:0]          i_num_vec,
    input  logic                      i_w_valid,
    output logic                      o_w_ready,
    input  logic [COLS*bit_width-1:0] i_w_data,
    input  logic                      i_f_valid,
    output logic                      o_f_ready,
    input  logic [ROWS*bit_width-1:0] i_f_data,
    output logic                      o_arr_control,
    output logic [COLS*bit_width-1:0] o_arr_weight,
    output logic [ROWS*bit_width-1:0] o_arr_data,
    output logic [ROWS-1:0]           o_arr_vld,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int PH_W  = phase_cnt_w(ROWS, COLS);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    feeder_state_t             r_state, w_state_next;
    logic [PH_W-1:0]           r_cnt, w_cnt_next;
    logic [CNT_W-1:0]          r_vcnt, w_vcnt_next, w_vcnt_inc;
    logic [CNT_W-1:0]          r_num_vec, w_num_vec_next;
    logic [COLS*bit_width-1:0] r_wbuf [ROWS];

    logic                      r_w_ready, r_f_ready, r_control, r_busy, r_done;
    logic [COLS*bit_width-1:0] r_weight;

    logic                      w_w_acc, w_f_acc;
    logic                      w_control_next, w_done_next;
    logic [COLS*bit_width-1:0] w_weight_next;
    logic [IDX_W-1:0]          w_widx;

    assign w_w_acc    = r_w_ready & i_w_valid;
    assign w_f_acc    = r_f_ready & i_f_valid;
    assign w_vcnt_inc = r_vcnt + 1'b1;
    // bottom row goes in first so it has been pushed furthest down after ROWS shifts
    assign w_widx     = IDX_W'(ROWS - 1) - r_cnt[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_vcnt    <= '0;
            r_num_vec <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_vcnt    <= w_vcnt_next;
            r_num_vec <= w_num_vec_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_vcnt_next    = r_vcnt;
        w_num_vec_next = r_num_vec;
        w_control_next = 1'b0;
        w_weight_next  = '0;
        w_done_next    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next   = WCOL;
                    w_cnt_next     = '0;
                    w_vcnt_next    = '0;
                    w_num_vec_next = i_num_vec;
                end
            end
            WCOL: begin
                if (w_w_acc) begin
                    if (r_cnt == PH_W'(ROWS - 1)) begin
                        w_state_next = WSHIFT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            WSHIFT: begin
                w_control_next = READ_WEIGHT_DATA;
                w_weight_next  = r_wbuf[w_widx];
                if (r_cnt == PH_W'(ROWS - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_num_vec == '0) ? DRAIN : STREAM;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STREAM: begin
                // leaving on the final accept keeps the count saturated at num_vec
                if (w_f_acc) begin
                    w_vcnt_next = w_vcnt_inc;
                    if (w_vcnt_inc == r_num_vec) begin
                        w_state_next = DRAIN;
                        w_cnt_next   = '0;
                    end
                end
            end
            DRAIN: begin
                if (r_cnt == PH_W'(ROWS + COLS - 1)) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // handshake/busy flops load from the next state so they line up with r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_ready <= 1'b0;
            r_f_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_control <= 1'b0;
            r_weight  <= '0;
            for (int k = 0; k < ROWS; k++) begin
                r_wbuf[k] <= '0;
            end
        end else begin
            r_w_ready <= (w_state_next == WCOL);
            r_f_ready <= (w_state_next == STREAM);
            r_busy    <= (w_state_next != IDLE);
            r_done    <= w_done_next;
            r_control <= w_control_next;
            r_weight  <= w_weight_next;
            if (w_w_acc) begin
                r_wbuf[r_cnt[IDX_W-1:0]] <= i_w_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            logic [bit_width-1:0] w_lane_in;
            assign w_lane_in = w_f_acc ? i_f_data[gi*bit_width +: bit_width] : '0;
            skew_line #(
                .bit_width(bit_width),
                .DELAY    (gi + 1)
            ) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .i_data(w_lane_in),
                .i_vld (w_f_acc),
                .o_data(o_arr_data[gi*bit_width +: bit_width]),
                .o_vld (o_arr_vld[gi])
            );
        end
    endgenerate

    assign o_w_ready     = r_w_ready;
    assign o_f_ready     = r_f_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_arr_control = r_control;
    assign o_arr_weight  = r_weight;

endmodule

// File: tb/tb_mha_array_feeder.sv
// Scoreboard bench for mha_array_feeder: stimulus pushes expected weight/lane/done events with
// their due cycle; a negedge monitor pops and compares whenever the feeder presents them.
module tb_mha_array_feeder;

    localparam int BW    = 8;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = 8;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_start;
    logic [CNT_W-1:0]     i_num_vec;
    logic                 i_w_valid;
    logic                 o_w_ready;
    logic [COLS*BW-1:0]   i_w_data;
    logic                 i_f_valid;
    logic                 o_f_ready;
    logic [ROWS*BW-1:0]   i_f_data;
    logic                 o_arr_control;
    logic [COLS*BW-1:0]   o_arr_weight;
    logic [ROWS*BW-1:0]   o_arr_data;
    logic [ROWS-1:0]      o_arr_vld;
    logic                 o_busy;
    logic                 o_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t wq[$];
    exp_t lane_q[ROWS][$];
    exp_t done_q[$];

    logic [31:0] wt[4];
    logic [31:0] ft[8];
    bit          pat[8];
    int          patlen;

    mha_array_feeder #(
        .bit_width(BW), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_num_vec    (i_num_vec),
        .i_w_valid    (i_w_valid),
        .o_w_ready    (o_w_ready),
        .i_w_data     (i_w_data),
        .i_f_valid    (i_f_valid),
        .o_f_ready    (o_f_ready),
        .i_f_data     (i_f_data),
        .o_arr_control(o_arr_control),
        .o_arr_weight (o_arr_weight),
        .o_arr_data   (o_arr_data),
        .o_arr_vld    (o_arr_vld),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event got none/unexpected (cycle %0d)", name, cyc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    o_busy, 0);
        check({tag, "_w_ready"}, o_w_ready, 0);
        check({tag, "_f_ready"}, o_f_ready, 0);
        check({tag, "_control"}, o_arr_control, 0);
        check({tag, "_weight"},  o_arr_weight, 0);
        check({tag, "_data"},    o_arr_data, 0);
        check({tag, "_vld"},     o_arr_vld, 0);
        check({tag, "_done"},    o_done, 0);
    endtask

    // monitor: pops expectations whenever the feeder drives control, lane-valid or done
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (o_arr_control) begin
                if (wq.size() == 0) flag("unexpected_control");
                else begin
                    e = wq.pop_front();
                    check("arr_weight", o_arr_weight, e.val);
                    check("weight_cycle", cyc, e.cyc);
                    check("data_during_shift", {o_arr_vld, o_arr_data}, 0);
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (o_arr_vld[r]) begin
                    if (lane_q[r].size() == 0) flag("unexpected_lane_vld");
                    else begin
                        e = lane_q[r].pop_front();
                        check("lane_value", o_arr_data[r*BW +: BW], e.val);
                        check("lane_cycle", cyc, e.cyc);
                    end
                end else if (o_busy) begin
                    check("bubble_zero", o_arr_data[r*BW +: BW], 0);
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) flag("unexpected_done");
                else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("busy_at_done", o_busy, 0);
                end
            end
        end
    end

    task automatic reset_mid();
        rst_n     = 1'b0;
        i_f_valid = 1'b0;
        #1;
        check_all_zero("async_rst");
        wq.delete();
        done_q.delete();
        for (int r = 0; r < ROWS; r++) lane_q[r].delete();
        repeat (2) @(negedge clk);
        check_all_zero("held_rst");
        rst_n = 1'b1;
    endtask

    task automatic do_tile(input int nv, input int wgap, input int abort_at);
        int k, g, tmo, acc, p, last;
        exp_t e;
        last = 0;
        @(negedge clk);
        i_start   = 1'b1;
        i_num_vec = CNT_W'(nv);
        @(negedge clk);
        i_start = 1'b0;
        k = 0; g = 0; tmo = 0;
        while (k < ROWS && tmo < 100) begin
            if (g < wgap) begin
                i_w_valid = 1'b0;
                check("w_ready_while_waiting", o_w_ready, 1);
                check("no_control_while_waiting", o_arr_control, 0);
                g++;
            end else begin
                i_w_valid = 1'b1;
                i_w_data  = wt[k];
                if (o_w_ready) begin
                    if (k == ROWS - 1) begin
                        last = cyc;
                        for (int i = 0; i < ROWS; i++) begin
                            e.val = wt[ROWS-1-i];
                            e.cyc = cyc + 2 + i;
                            wq.push_back(e);
                        end
                    end
                    k++;
                end
            end
            @(negedge clk);
            tmo++;
        end
        i_w_valid = 1'b0;
        i_w_data  = 32'hDEADBEEF;
        if (k < ROWS) flag("weight_load_timeout");

        if (nv == 0) begin
            e.val = 0;
            e.cyc = last + 2*ROWS + COLS + 1;
            done_q.push_back(e);
            repeat (6) @(negedge clk);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end else begin
            tmo = 0;
            while (!o_f_ready && tmo < 50) begin
                @(negedge clk);
                tmo++;
            end
            check("f_ready_rise_cycle", cyc, last + ROWS + 1);
            acc = 0; p = 0; tmo = 0;
            while (acc < nv && tmo < 200) begin
                if (abort_at >= 0 && acc == abort_at) begin
                    reset_mid();
                    return;
                end
                i_f_valid = pat[p % patlen];
                i_f_data  = ft[acc];
                if (i_f_valid && o_f_ready) begin
                    for (int r = 0; r < ROWS; r++) begin
                        e.val = 32'(ft[acc][r*BW +: BW]);
                        e.cyc = cyc + r + 1;
                        lane_q[r].push_back(e);
                    end
                    acc++;
                    last = cyc;
                end
                p++;
                @(negedge clk);
                tmo++;
            end
            i_f_valid = 1'b0;
            if (acc < nv) flag("feature_accept_timeout");
            check("f_ready_drop", o_f_ready, 0);
            e.val = 0;
            e.cyc = last + ROWS + COLS + 1;
            done_q.push_back(e);
        end

        tmo = 0;
        while (done_q.size() != 0 && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (done_q.size() != 0) begin
            flag("done_timeout");
            done_q.delete();
        end
        @(negedge clk);
        check("idle_busy_after_done", o_busy, 0);
        check("idle_w_ready_after_done", o_w_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_num_vec = '0;
        i_w_valid = 1'b0; i_w_data = '0; i_f_valid = 1'b0; i_f_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // weight order + single-vector skew
        wt = '{32'h11121314, 32'h22232425, 32'h33343536, 32'h44454647};
        ft[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        pat[0] = 1'b1; patlen = 1;
        do_tile(1, 0, -1);

        // bubbles: valid toggles 1,0,1,0,1
        wt = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};
        ft[0] = 32'h0A0B0C0D; ft[1] = 32'h10203040; ft[2] = 32'hF0E0D0C0;
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1; patlen = 5;
        do_tile(3, 0, -1);

        // weight backpressure then drain/done with two vectors
        wt = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        ft[0] = 32'h55AA55AA; ft[1] = 32'h7F80FF01;
        pat[0] = 1'b1; patlen = 1;
        do_tile(2, 5, -1);

        // no vectors; start pulsed during drain must be ignored
        wt = '{32'h99887766, 32'h55443322, 32'h11FFEEDD, 32'hCCBBAA00};
        do_tile(0, 0, -1);

        // reset mid-stream, then a fresh tile
        wt = '{32'h0F0F0F0F, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'hC3C3C3C3};
        ft[0] = 32'h01010101; ft[1] = 32'h02020202; ft[2] = 32'h03030303;
        ft[3] = 32'h04040404; ft[4] = 32'h05050505;
        do_tile(5, 0, 2);
        @(negedge clk);
        check("idle_after_reset", o_busy, 0);
        wt = '{32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 32'h87654321};
        ft[0] = 32'hDEADBEEF; ft[1] = 32'hCAFEF00D;
        do_tile(2, 0, -1);

        repeat (3) @(negedge clk);
        check("weight_queue_empty", wq.size(), 0);
        for (int r = 0; r < ROWS; r++) check("lane_queue_empty", lane_q[r].size(), 0);
        check("done_queue_empty", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
